umich_sub_uns_seq: RTL and testbench

- Multi-cycle, chunk-serial unsigned subtractor: Z = A - B, with a borrow (underflow) flag.
- Companion to the single-cycle generic unsigned adder cell; it provides the subtract direction of the same arithmetic.
- Used where a wide single-cycle subtract is too costly. Processes one CHUNK-bit slice per clock with a registered borrow chain.
- Valid/ready handshake on both the operand side and the result side.

---
 rtl/umich_sub_uns_seq_pkg.sv | 21 ++
 rtl/umich_sub_uns_seq_if.sv | 24 ++
 rtl/umich_sub_chunk.sv | 17 +
 rtl/umich_sub_uns_seq.sv | 126 ++++++++++++
 tb/tb_umich_sub_uns_seq.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/umich_sub_uns_seq_pkg.sv
// Shared arithmetic definitions for the chunk-serial unsigned subtractor.
// Holds the controller state encoding and the index-width helper.
package umich_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Ceiling log2; 0 and 1 both map to 0, callers clamp to a 1-bit minimum.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >>> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/umich_sub_uns_seq_if.sv
// Operand/result handshake bundle for umich_sub_uns_seq.
// master = producer/consumer side, slave = the subtractor.
interface umich_sub_uns_seq_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Z;
    logic             borrow;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Z, borrow
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Z, borrow
    );
endinterface

// File: rtl/umich_sub_chunk.sv
// Combinational CHUNK-bit subtract slice with borrow-in and borrow-out.
module umich_sub_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             borrow_in,
    output logic [CHUNK-1:0] diff,
    output logic             borrow_out
);
    logic [CHUNK:0] wide;

    // The extra MSB goes to 1 exactly when the slice underflows.
    assign wide       = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, borrow_in};
    assign diff       = wide[CHUNK-1:0];
    assign borrow_out = wide[CHUNK];
endmodule

// File: rtl/umich_sub_uns_seq.sv
// Multi-cycle chunk-serial unsigned subtractor Z = A - B with borrow flag.
// Define UMICH_SUB_SAT_EN to clamp Z to zero whenever the subtract underflows.
module umich_sub_uns_seq
    import umich_arith_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic                 clocked_on,
    input  logic                 clear_n,
    input  logic                 synch_clear,
    umich_sub_uns_seq_if.slave   bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
            $error("umich_sub_uns_seq: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    sub_state_t       state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             borrow_reg;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] z_reg;
    logic             borrow_q;
    logic             out_valid_q;

    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK-1:0] diff;
    logic             chunk_borrow;
    logic [WIDTH-1:0] next_work;
    logic [WIDTH-1:0] z_final;

    assign a_slice = a_reg[int'(idx) * CHUNK +: CHUNK];
    assign b_slice = b_reg[int'(idx) * CHUNK +: CHUNK];

    umich_sub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a          (a_slice),
        .b          (b_slice),
        .borrow_in  (borrow_reg),
        .diff       (diff),
        .borrow_out (chunk_borrow)
    );

    // Partial results build up in a shadow register so Z only moves on entry to DONE.
    always_comb begin
        next_work = work;
        next_work[int'(idx) * CHUNK +: CHUNK] = diff;
    end

`ifdef UMICH_SUB_SAT_EN
    assign z_final = chunk_borrow ? '0 : next_work;
`else
    assign z_final = next_work;
`endif

    always_ff @(posedge clocked_on or negedge clear_n) begin
        if (!clear_n) begin
            state       <= IDLE;
            idx         <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            borrow_reg  <= 1'b0;
            work        <= '0;
            z_reg       <= '0;
            borrow_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (synch_clear) begin
            state       <= IDLE;
            idx         <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            borrow_reg  <= 1'b0;
            work        <= '0;
            z_reg       <= '0;
            borrow_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg      <= bus.A;
                        b_reg      <= bus.B;
                        borrow_reg <= 1'b0;
                        idx        <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    work       <= next_work;
                    borrow_reg <= chunk_borrow;
                    if (idx == LAST_IDX) begin
                        idx         <= '0;
                        z_reg       <= z_final;
                        borrow_q    <= chunk_borrow;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.Z         = z_reg;
    assign bus.borrow    = borrow_q;
endmodule

// File: tb/tb_umich_sub_uns_seq.sv
// Directed and randomised self-checking bench for umich_sub_uns_seq (64/16 defaults).
// Expected Z follows UMICH_SUB_SAT_EN when the bench is compiled with it.
module tb_umich_sub_uns_seq;
    localparam int WIDTH = 64;
    localparam int CHUNK = 16;
    localparam int LAT   = WIDTH / CHUNK;

    logic clocked_on;
    logic clear_n;
    logic synch_clear;
    int   errors;
    int   checks;
    int   accepts;
    int   results;

    umich_sub_uns_seq_if #(.WIDTH(WIDTH)) bus ();

    umich_sub_uns_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clocked_on  (clocked_on),
        .clear_n     (clear_n),
        .synch_clear (synch_clear),
        .bus         (bus)
    );

    initial clocked_on = 1'b0;
    always #5 clocked_on = ~clocked_on;

    task automatic step();
        @(posedge clocked_on);
        #1;
    endtask

    // Drives one operand pair through the input handshake; ok=0 if in_ready never came.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output bit ok);
        int waited;
        waited = 0;
        while (!bus.in_ready && waited < 50) begin
            step();
            waited++;
        end
        ok = bus.in_ready;
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        if (ok) accepts++;
    endtask

    task automatic wait_done(input int limit, output int lat);
        lat = 0;
        while (!bus.out_valid && lat < limit) begin
            step();
            lat++;
        end
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        results++;
    endtask

    task automatic test_reset();
        bit ok;
        int lat;
        clear_n = 1'b0;
        #3;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.Z !== 64'h0) begin errors++; $display("[TB] FAIL reset_z: got %h expected 0", bus.Z); end
        checks++; if (bus.borrow !== 1'b0) begin errors++; $display("[TB] FAIL reset_borrow: got %b expected 0", bus.borrow); end
        @(negedge clocked_on);
        clear_n = 1'b1;
        step();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end

        applyStimulus(64'd5, 64'd3, ok);
        wait_done(20, lat);
        checks++; if (bus.Z !== 64'd2) begin errors++; $display("[TB] FAIL small_sub_z: got %h expected 2", bus.Z); end
        take_result();

        // Interrupt a second operation after two chunks with the async reset.
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ok);
        step();
        step();
        clear_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midbusy_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.Z !== 64'h0) begin errors++; $display("[TB] FAIL midbusy_z: got %h expected 0", bus.Z); end
        checks++; if (bus.borrow !== 1'b0) begin errors++; $display("[TB] FAIL midbusy_borrow: got %b expected 0", bus.borrow); end
        @(negedge clocked_on);
        clear_n = 1'b1;
        step();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); end
        applyStimulus(64'd100, 64'd58, ok);
        wait_done(20, lat);
        checks++; if (bus.Z !== 64'd42 || bus.borrow !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_op: got Z=%h borrow=%b expected Z=2a borrow=0", bus.Z, bus.borrow); end
        take_result();
    endtask

    task automatic test_cross_borrow();
        bit ok;
        int lat;
        applyStimulus(64'h0000_0001_0000_0000, 64'h1, ok);
        wait_done(20, lat);
        checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL cross_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (bus.Z !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("[TB] FAIL cross_z: got %h expected 00000000ffffffff", bus.Z); end
        checks++; if (bus.borrow !== 1'b0) begin errors++; $display("[TB] FAIL cross_borrow: got %b expected 0", bus.borrow); end
        take_result();
    endtask

    task automatic test_underflow();
        bit ok;
        int lat;
        logic [WIDTH-1:0] exp_z;
`ifdef UMICH_SUB_SAT_EN
        exp_z = 64'h0;
`else
        exp_z = 64'hFFFF_FFFF_FFFF_FFFF;
`endif
        applyStimulus(64'h0, 64'h1, ok);
        wait_done(20, lat);
        checks++; if (bus.Z !== exp_z) begin errors++; $display("[TB] FAIL underflow_z: got %h expected %h", bus.Z, exp_z); end
        checks++; if (bus.borrow !== 1'b1) begin errors++; $display("[TB] FAIL underflow_borrow: got %b expected 1", bus.borrow); end
        take_result();
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        int bad;
        applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, ok);
        wait_done(20, lat);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = c[0];
            bus.A        = 64'h0;
            bus.B        = 64'd5 + 64'(c);
            step();
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.Z !== 64'h0246_8ACF_1357_9BCF || bus.borrow !== 1'b0) bad++;
        end
        bus.in_valid = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL stall_hold: got %0d bad cycles expected 0 (Z=%h borrow=%b)", bad, bus.Z, bus.borrow); end
        take_result();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_release_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_ready: got %b expected 1", bus.in_ready); end
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL stall_no_capture: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_abort();
        bit ok;
        int lat;
        int bad;
        applyStimulus(64'h8000_0000_0000_0000, 64'h1, ok);
        step();
        synch_clear = 1'b1;
        step();
        synch_clear = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_idle: got in_ready %b expected 1", bus.in_ready); end
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid !== 1'b0) bad++;
            step();
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL abort_no_valid: got %0d valid cycles expected 0", bad); end
        applyStimulus(64'h10, 64'h10, ok);
        wait_done(20, lat);
        checks++; if (bus.out_valid !== 1'b1 || bus.Z !== 64'h0 || bus.borrow !== 1'b0) begin errors++; $display("[TB] FAIL abort_next_op: got valid=%b Z=%h borrow=%b expected 1/0/0", bus.out_valid, bus.Z, bus.borrow); end
        take_result();
    endtask

    task automatic test_random();
        bit ok;
        bit got;
        int lat;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_z;
        logic             exp_b;
        for (int n = 0; n < 500; n++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (n % 7 == 0) b = a;
            if (n % 5 == 1) b[63:32] = a[63:32];
            exp_b = (a < b);
            exp_z = a - b;
`ifdef UMICH_SUB_SAT_EN
            if (exp_b) exp_z = '0;
`endif
            applyStimulus(a, b, ok);
            got = 1'b0;
            for (int c = 0; c < 100 && !got; c++) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                if (bus.out_valid && bus.out_ready) begin
                    got = 1'b1;
                    results++;
                    checks++;
                    if (bus.Z !== exp_z || bus.borrow !== exp_b) begin
                        errors++;
                        $display("[TB] FAIL random_%0d: got Z=%h borrow=%b expected Z=%h borrow=%b", n, bus.Z, bus.borrow, exp_z, exp_b);
                    end
                end
                step();
            end
            bus.out_ready = 1'b0;
            if (!got) begin
                checks++; errors++;
                $display("[TB] FAIL random_timeout_%0d: got no result expected one", n);
            end
        end
        checks++; if (results !== accepts) begin errors++; $display("[TB] FAIL accept_vs_result: got %0d results expected %0d", results, accepts); end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        accepts       = 0;
        results       = 0;
        clear_n       = 1'b0;
        synch_clear   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        test_reset();
        test_cross_borrow();
        test_underflow();
        test_backpressure();
        test_abort();
        accepts = 0;
        results = 0;
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
